ball_ctrl: RTL

Ball motion controller for the pong datapath. It consumes the registered `coll_paddle` / `coll_wall` flags from the collision detector and owns the ball state that the detector and the video renderer read back. The ball state is position, horizontal direction and speed. Once per frame tick it advances the ball, bounces it off the top/bottom table edges and paddles, and detects points. It also runs the serve / point-hold sequence.

---
 rtl/ball_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ball_ctrl.sv
// Pong ball motion controller: serve, per-frame motion, bounces,
// point detection and post-point hold.
`ifndef LEFT
`define LEFT 1'b0
`endif
`ifndef RIGHT
`define RIGHT 1'b1
`endif

module ball_ctrl #(
  parameter logic [10:0] TABLE_TOP    = 11'd8,
  parameter logic [10:0] TABLE_BOTTOM = 11'd472,
  parameter logic [10:0] BALL_VSIZE   = 11'd8,
  parameter logic [10:0] START_H      = 11'd316,
  parameter logic [10:0] START_V      = 11'd236,
  parameter logic [3:0]  START_SPEED  = 4'd2,
  parameter logic [3:0]  MAX_SPEED    = 4'd9,
  parameter logic [3:0]  VSPEED       = 4'd2,
  parameter logic [7:0]  HOLD_FRAMES  = 8'd60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        serve,
  input  logic        coll_paddle,
  input  logic        coll_wall,
  output logic [10:0] ball_h,
  output logic [10:0] ball_v,
  output logic        ball_dir,
  output logic        ball_vdir,
  output logic [3:0]  ball_speed,
  output logic        in_play,
  output logic        point_left,
  output logic        point_right
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        dir_q, dir_d;
  logic        vdir_q, vdir_d;
  logic [3:0]  spd_q, spd_d;
  logic        ip_q, ip_d;
  logic        pl_q, pl_d;
  logic        pr_q, pr_d;
  logic        sdir_q, sdir_d;
  logic [7:0]  hold_q, hold_d;

  logic [11:0] vsum;
  logic [11:0] vtop;
  logic [10:0] vert_v;
  logic        vert_vdir;
  logic [4:0]  spd_inc;
  logic [3:0]  spd_sat;
  logic [7:0]  hold_init;

  assign vsum = {1'b0, v_q} + {1'b0, BALL_VSIZE}
              + {8'd0, VSPEED};
  assign vtop = {1'b0, TABLE_TOP} + {8'd0, VSPEED};
  assign spd_inc = {1'b0, spd_q} + 5'd1;
  assign spd_sat = (spd_inc > {1'b0, MAX_SPEED})
                 ? MAX_SPEED : spd_inc[3:0];
  assign hold_init = (HOLD_FRAMES == 8'd0)
                   ? 8'd1 : HOLD_FRAMES;

  always_comb begin
    vert_v    = v_q;
    vert_vdir = vdir_q;
    if (vdir_q) begin
      if (vsum >= {1'b0, TABLE_BOTTOM}) begin
        vert_v    = TABLE_BOTTOM - BALL_VSIZE;
        vert_vdir = 1'b0;
      end else begin
        vert_v = v_q + {7'd0, VSPEED};
      end
    end else begin
      if ({1'b0, v_q} <= vtop) begin
        vert_v    = TABLE_TOP;
        vert_vdir = 1'b1;
      end else begin
        vert_v = v_q - {7'd0, VSPEED};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    dir_d   = dir_q;
    vdir_d  = vdir_q;
    spd_d   = spd_q;
    pl_d    = 1'b0;
    pr_d    = 1'b0;
    sdir_d  = sdir_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (serve) begin
          state_d = MOVE;
          dir_d   = sdir_q;
        end
      end
      MOVE: begin
        // collision flags only trusted here; stale/X elsewhere
        if (tick) begin
          if (coll_wall) begin
            state_d = HOLD;
            hold_d  = hold_init;
            if (dir_q == `LEFT) begin
              pr_d   = 1'b1;
              sdir_d = `LEFT;
            end else begin
              pl_d   = 1'b1;
              sdir_d = `RIGHT;
            end
          end else begin
            v_d    = vert_v;
            vdir_d = vert_vdir;
            if (coll_paddle) begin
              dir_d = ~dir_q;
              spd_d = spd_sat;
            end else if (dir_q == `RIGHT) begin
              h_d = h_q + {7'd0, spd_q};
            end else begin
              h_d = h_q - {7'd0, spd_q};
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          hold_d = hold_q - 8'd1;
          if (hold_q <= 8'd1) begin
            state_d = IDLE;
            hold_d  = 8'd0;
            h_d     = START_H;
            v_d     = START_V;
            spd_d   = START_SPEED;
            vdir_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    ip_d = (state_d == MOVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= START_H;
      v_q     <= START_V;
      dir_q   <= `RIGHT;
      vdir_q  <= 1'b1;
      spd_q   <= START_SPEED;
      ip_q    <= 1'b0;
      pl_q    <= 1'b0;
      pr_q    <= 1'b0;
      sdir_q  <= `RIGHT;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      dir_q   <= dir_d;
      vdir_q  <= vdir_d;
      spd_q   <= spd_d;
      ip_q    <= ip_d;
      pl_q    <= pl_d;
      pr_q    <= pr_d;
      sdir_q  <= sdir_d;
      hold_q  <= hold_d;
    end
  end

  assign ball_h      = h_q;
  assign ball_v      = v_q;
  assign ball_dir    = dir_q;
  assign ball_vdir   = vdir_q;
  assign ball_speed  = spd_q;
  assign in_play     = ip_q;
  assign point_left  = pl_q;
  assign point_right = pr_q;

endmodule
